hyperram_seq_mp: RTL and testbench

- Multi-port HyperRAM transaction sequencer; the next-generation replacement for the single-port top-level sequencer.
- Arbitrates NUM_PORTS requesters and builds the 48-bit command/address (CA) word internally.
- Drives CA, initial latency (fixed or doubled), burst data and CS# recovery directly on the existing 16-bit-per-clock PHY signals (csn/oe_clk/oe_data/datain/dataout/rwds).
- Supports variable-length linear bursts and register space.

---
 rtl/hrc_pkg.sv | 37 +++
 rtl/hrc_arbiter.sv | 58 +++++
 rtl/hyperram_seq_mp.sv | 274 +++++++++++++++++++++++++++
 tb/tb_hyperram_seq_mp.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hrc_pkg.sv
// Shared types and helpers for the multi-port HyperRAM sequencer:
// FSM state encoding, command/address bit positions and CA word builder.
package hrc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CA0,
      CA1,
      CA2,
      LAT,
      WDATA,
      RDATA,
      RECOV
   } hrc_state_e;

   localparam int unsigned CA_RW_BIT    = 47;
   localparam int unsigned CA_AS_BIT    = 46;
   localparam int unsigned CA_BURST_BIT = 45;
   localparam int unsigned CA_ROW_MSB   = 44;
   localparam int unsigned CA_ROW_LSB   = 16;
   localparam int unsigned CA_COL_W     = 3;

   // Word address is already truncated/extended to 32 bits by the caller.
   function automatic logic [47:0] build_ca(input logic        write,
                                            input logic        is_reg,
                                            input logic [31:0] addr);
      logic [47:0] ca;
      ca                          = '0;
      ca[CA_RW_BIT]               = ~write;
      ca[CA_AS_BIT]               = is_reg;
      ca[CA_BURST_BIT]            = 1'b1;
      ca[CA_ROW_MSB:CA_ROW_LSB]   = addr[31:3];
      ca[CA_COL_W-1:0]            = addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hrc_arbiter.sv
// Requester arbiter: fixed lowest-index priority by default, round-robin
// starting at a rotating pointer when HRC_RR_ARB_EN is defined.
module hrc_arbiter #(
   parameter int unsigned NUM_PORTS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 adv,
   output logic [NUM_PORTS-1:0] gnt,
   output logic                 valid
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef HRC_RR_ARB_EN
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gnt_idx;
   int unsigned   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      valid   = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = (32'(ptr_q) + i) % NUM_PORTS;
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            valid    = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (adv) ptr_d = PW'((32'(gnt_idx) + 1) % NUM_PORTS);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`else
   logic unused_arb;
   assign unused_arb = ^{clk, rst, adv};

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!valid && req[i]) begin
            gnt[i] = 1'b1;
            valid  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/hyperram_seq_mp.sv
// Multi-port HyperRAM transaction sequencer driving the 16-bit-per-clock PHY.
// Arbitration mode selected by HRC_RR_ARB_EN (see hrc_arbiter).
module hyperram_seq_mp
   import hrc_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LEN_W     = 6,
   parameter int unsigned LAT_CYC   = 6,
   parameter int unsigned RECOV_CYC = 4,
   parameter int unsigned RD_TMO    = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS-1:0]        req_reg,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
   input  logic [NUM_PORTS*16-1:0]     wr_data,
   output logic [NUM_PORTS-1:0]        wr_ready,
   output logic [15:0]                 rd_data,
   output logic [NUM_PORTS-1:0]        rd_valid,
   output logic [NUM_PORTS-1:0]        done,
   output logic                        err,
   output logic                        csn,
   output logic                        oe_clk,
   output logic                        oe_data,
   output logic [15:0]                 datain,
   input  logic [15:0]                 dataout,
   input  logic                        rwds_in,
   output logic                        rwds_out,
   output logic                        rwds_oe
);

   localparam int unsigned PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned LEN_MAX  = 2 ** LEN_W;
   localparam int unsigned CNT_MAX0 = (2 * LAT_CYC > RECOV_CYC) ? 2 * LAT_CYC : RECOV_CYC;
   localparam int unsigned CNT_MAX  = (CNT_MAX0 > LEN_MAX) ? CNT_MAX0 : LEN_MAX;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned TMO_W    = $clog2(RD_TMO + 1);

   localparam logic [CNT_W-1:0] LAT1_LD  = CNT_W'(LAT_CYC - 1);
   localparam logic [CNT_W-1:0] LAT2_LD  = CNT_W'(2 * LAT_CYC - 1);
   localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TMO - 1);

   hrc_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [47:0]          ca_q, ca_d;
   logic [NUM_PORTS-1:0] gnt_q, gnt_d;
   logic [PW-1:0]        port_q, port_d;
   logic                 write_q, write_d;
   logic                 reg_q, reg_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 lat_dbl_q, lat_dbl_d;

   logic                 csn_q, csn_d;
   logic                 oe_clk_q, oe_clk_d;
   logic                 oe_data_q, oe_data_d;
   logic                 rwds_oe_q, rwds_oe_d;
   logic                 rwds_out_q, rwds_out_d;
   logic [15:0]          datain_q, datain_d;
   logic [15:0]          rd_data_q, rd_data_d;
   logic [NUM_PORTS-1:0] req_ready_q, req_ready_d;
   logic [NUM_PORTS-1:0] wr_ready_q, wr_ready_d;
   logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;
   logic [NUM_PORTS-1:0] done_q, done_d;
   logic                 err_q, err_d;

   logic [NUM_PORTS-1:0] arb_gnt;
   logic                 arb_valid;
   logic                 arb_adv;

   hrc_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .adv   (arb_adv),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      ca_d        = ca_q;
      gnt_d       = gnt_q;
      port_d      = port_q;
      write_d     = write_q;
      reg_d       = reg_q;
      len_d       = len_q;
      lat_dbl_d   = lat_dbl_q;
      arb_adv     = 1'b0;
      csn_d       = 1'b1;
      oe_clk_d    = 1'b0;
      oe_data_d   = 1'b0;
      rwds_oe_d   = 1'b0;
      rwds_out_d  = 1'b0;
      datain_d    = '0;
      rd_data_d   = rd_data_q;
      req_ready_d = '0;
      wr_ready_d  = '0;
      rd_valid_d  = '0;
      done_d      = '0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               arb_adv     = 1'b1;
               gnt_d       = arb_gnt;
               req_ready_d = arb_gnt;
               state_d     = CA0;
               for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                  if (arb_gnt[i]) begin
                     port_d  = PW'(i);
                     write_d = req_write[i];
                     reg_d   = req_reg[i];
                     len_d   = req_len[i*LEN_W +: LEN_W];
                     ca_d    = build_ca(req_write[i], req_reg[i],
                                        32'(req_addr[i*ADDR_W +: ADDR_W]));
                  end
               end
            end
         end
         CA0: begin
            lat_dbl_d = rwds_in;
            state_d   = CA1;
         end
         CA1: state_d = CA2;
         CA2: begin
            if (write_q && reg_q) begin
               state_d = WDATA;
               cnt_d   = '0;
               len_d   = '0;
            end else begin
               state_d = LAT;
               cnt_d   = lat_dbl_q ? LAT2_LD : LAT1_LD;
            end
         end
         LAT: begin
            if (cnt_q == '0) begin
               state_d = write_q ? WDATA : RDATA;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WDATA: begin
            if (cnt_q == CNT_W'(len_q)) state_d = RECOV;
            else                         cnt_d   = cnt_q + CNT_W'(1);
         end
         RDATA: begin
            if (rwds_in) begin
               rd_data_d  = dataout;
               rd_valid_d = gnt_q;
               tmo_d      = '0;
               if (cnt_q == CNT_W'(len_q)) state_d = RECOV;
               else                         cnt_d   = cnt_q + CNT_W'(1);
            end else if (tmo_q == TMO_LAST) begin
               state_d = RECOV;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         RECOV: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase

      if (state_d == RECOV && state_q != RECOV) begin
         done_d = gnt_q;
         cnt_d  = RECOV_LD;
      end

      // Pin values are decoded from the next state so the registered pins line up with state_q.
      case (state_d)
         CA0, CA1, CA2: begin
            csn_d     = 1'b0;
            oe_clk_d  = 1'b1;
            oe_data_d = 1'b1;
            if (state_d == CA0)      datain_d = ca_d[47:32];
            else if (state_d == CA1) datain_d = ca_d[31:16];
            else                     datain_d = ca_d[15:0];
         end
         LAT, RDATA: begin
            csn_d    = 1'b0;
            oe_clk_d = 1'b1;
         end
         WDATA: begin
            csn_d      = 1'b0;
            oe_clk_d   = 1'b1;
            oe_data_d  = 1'b1;
            rwds_oe_d  = 1'b1;
            datain_d   = wr_data[32'(port_d)*16 +: 16];
            wr_ready_d = gnt_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tmo_q       <= '0;
         ca_q        <= '0;
         gnt_q       <= '0;
         port_q      <= '0;
         write_q     <= 1'b0;
         reg_q       <= 1'b0;
         len_q       <= '0;
         lat_dbl_q   <= 1'b0;
         csn_q       <= 1'b1;
         oe_clk_q    <= 1'b0;
         oe_data_q   <= 1'b0;
         rwds_oe_q   <= 1'b0;
         rwds_out_q  <= 1'b0;
         datain_q    <= '0;
         rd_data_q   <= '0;
         req_ready_q <= '0;
         wr_ready_q  <= '0;
         rd_valid_q  <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         ca_q        <= ca_d;
         gnt_q       <= gnt_d;
         port_q      <= port_d;
         write_q     <= write_d;
         reg_q       <= reg_d;
         len_q       <= len_d;
         lat_dbl_q   <= lat_dbl_d;
         csn_q       <= csn_d;
         oe_clk_q    <= oe_clk_d;
         oe_data_q   <= oe_data_d;
         rwds_oe_q   <= rwds_oe_d;
         rwds_out_q  <= rwds_out_d;
         datain_q    <= datain_d;
         rd_data_q   <= rd_data_d;
         req_ready_q <= req_ready_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign csn       = csn_q;
   assign oe_clk    = oe_clk_q;
   assign oe_data   = oe_data_q;
   assign rwds_oe   = rwds_oe_q;
   assign rwds_out  = rwds_out_q;
   assign datain    = datain_q;
   assign rd_data   = rd_data_q;
   assign req_ready = req_ready_q;
   assign wr_ready  = wr_ready_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_hyperram_seq_mp.sv
// Directed bench for hyperram_seq_mp (two ports, LAT_CYC=6, RECOV_CYC=4, RD_TMO=64).
// wr_data is sampled on the edge that raises wr_ready; the bench then advances it.
module tb_hyperram_seq_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid, req_ready, req_write, req_reg;
   logic [63:0] req_addr;
   logic [11:0] req_len;
   logic [31:0] wr_data;
   logic [1:0]  wr_ready, rd_valid, done;
   logic [15:0] rd_data, datain, dataout;
   logic        err, csn, oe_clk, oe_data, rwds_in, rwds_out, rwds_oe;

   int checks   = 0;
   int failures = 0;

   hyperram_seq_mp #(
      .NUM_PORTS (2),
      .ADDR_W    (32),
      .LEN_W     (6),
      .LAT_CYC   (6),
      .RECOV_CYC (4),
      .RD_TMO    (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_reg   (req_reg),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .err       (err),
      .csn       (csn),
      .oe_clk    (oe_clk),
      .oe_data   (oe_data),
      .datain    (datain),
      .dataout   (dataout),
      .rwds_in   (rwds_in),
      .rwds_out  (rwds_out),
      .rwds_oe   (rwds_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_write = '0;
      req_reg   = '0;
      req_addr  = '0;
      req_len   = '0;
      wr_data   = '0;
      dataout   = '0;
      rwds_in   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      step(2);
      checks++;
      if ({csn, oe_clk, oe_data, rwds_oe, rwds_out} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_pins got=%b exp=10000", {csn, oe_clk, oe_data, rwds_oe, rwds_out});
      end
      checks++;
      if ({req_ready, wr_ready, rd_valid, done, err} !== 9'b0) begin
         failures++;
         $display("FAIL reset_status got=%b exp=0", {req_ready, wr_ready, rd_valid, done, err});
      end
      checks++;
      if (datain !== 16'h0000) begin
         failures++;
         $display("FAIL reset_datain got=%h exp=0000", datain);
      end
      rst = 1'b1;
      step(2);
      checks++;
      if ({csn, req_ready} !== 3'b100) begin
         failures++;
         $display("FAIL idle_no_req got=%b exp=100", {csn, req_ready});
      end
   endtask

   task automatic test_read();
      logic [15:0] w;
      req_valid     = 2'b01;
      req_write     = 2'b00;
      req_reg       = 2'b00;
      req_addr      = 64'h0000_0000_0000_0010;
      req_len[5:0]  = 6'd3;
      rwds_in       = 1'b0;
      step(1);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL rd_grant got=%b exp=01", req_ready);
      end
      checks++;
      if ({csn, oe_clk, oe_data, datain} !== {3'b011, 16'hA000}) begin
         failures++;
         $display("FAIL rd_ca0 got=%b/%h exp=011/a000", {csn, oe_clk, oe_data}, datain);
      end
      req_valid = 2'b00;
      step(1);
      checks++;
      if (datain !== 16'h0002) begin
         failures++;
         $display("FAIL rd_ca1 got=%h exp=0002", datain);
      end
      step(1);
      checks++;
      if ({req_ready, datain} !== {2'b00, 16'h0000}) begin
         failures++;
         $display("FAIL rd_ca2 got=%b/%h exp=00/0000", req_ready, datain);
      end
      for (int i = 0; i < 6; i++) begin
         step(1);
         checks++;
         if ({csn, oe_clk, oe_data, rd_valid} !== 5'b01000) begin
            failures++;
            $display("FAIL rd_lat%0d got=%b exp=01000", i, {csn, oe_clk, oe_data, rd_valid});
         end
      end
      w       = 16'hA5A0;
      rwds_in = 1'b1;
      dataout = w;
      step(1);
      checks++;
      if ({oe_data, rd_valid} !== 3'b000) begin
         failures++;
         $display("FAIL rd_first_cycle got=%b exp=000", {oe_data, rd_valid});
      end
      for (int k = 0; k < 4; k++) begin
         step(1);
         checks++;
         if ({rd_valid, rd_data} !== {2'b01, w}) begin
            failures++;
            $display("FAIL rd_word%0d got=%b/%h exp=01/%h", k, rd_valid, rd_data, w);
         end
         w       = w + 16'h0001;
         dataout = w;
      end
      checks++;
      if ({done, err, csn} !== 4'b0101) begin
         failures++;
         $display("FAIL rd_done got=%b exp=0101", {done, err, csn});
      end
      rwds_in = 1'b0;
      for (int r = 0; r < 3; r++) begin
         step(1);
         checks++;
         if ({csn, oe_clk, done, rd_valid} !== 6'b100000) begin
            failures++;
            $display("FAIL rd_recov%0d got=%b exp=100000", r, {csn, oe_clk, done, rd_valid});
         end
      end
      step(3);
   endtask

   task automatic test_write();
      req_valid       = 2'b10;
      req_write       = 2'b10;
      req_reg         = 2'b00;
      req_addr        = 64'h0000_0001_0000_0000;
      req_len         = {6'd1, 6'd0};
      wr_data         = {16'h1111, 16'h0000};
      rwds_in         = 1'b1;
      step(1);
      checks++;
      if ({req_ready, datain} !== {2'b10, 16'h2000}) begin
         failures++;
         $display("FAIL wr_ca0 got=%b/%h exp=10/2000", req_ready, datain);
      end
      req_valid = 2'b00;
      step(1);
      rwds_in = 1'b0;
      checks++;
      if (datain !== 16'h0000) begin
         failures++;
         $display("FAIL wr_ca1 got=%h exp=0000", datain);
      end
      step(1);
      checks++;
      if (datain !== 16'h0001) begin
         failures++;
         $display("FAIL wr_ca2 got=%h exp=0001", datain);
      end
      for (int i = 0; i < 12; i++) begin
         step(1);
         checks++;
         if ({wr_ready, oe_data, rwds_oe, csn} !== 5'b00000) begin
            failures++;
            $display("FAIL wr_lat%0d got=%b exp=00000", i, {wr_ready, oe_data, rwds_oe, csn});
         end
      end
      step(1);
      checks++;
      if ({wr_ready, oe_data, rwds_oe, rwds_out, csn, datain} !== {5'b10110, 1'b0, 16'h1111}) begin
         failures++;
         $display("FAIL wr_word0 got=%b/%b/%h exp=10110/0/1111", {wr_ready, oe_data, rwds_oe, rwds_out}, csn, datain);
      end
      wr_data[31:16] = 16'h2222;
      step(1);
      checks++;
      if ({wr_ready, datain} !== {2'b10, 16'h2222}) begin
         failures++;
         $display("FAIL wr_word1 got=%b/%h exp=10/2222", wr_ready, datain);
      end
      step(1);
      checks++;
      if ({done, wr_ready, csn, rwds_oe, oe_data} !== 7'b1000100) begin
         failures++;
         $display("FAIL wr_done got=%b exp=1000100", {done, wr_ready, csn, rwds_oe, oe_data});
      end
      step(5);
   endtask

   task automatic test_reg_write();
      req_valid    = 2'b01;
      req_write    = 2'b01;
      req_reg      = 2'b01;
      req_addr     = 64'h0000_0000_0000_1000;
      req_len      = {6'd0, 6'd5};
      wr_data      = {16'h0000, 16'hBEEF};
      step(1);
      checks++;
      if ({req_ready, datain} !== {2'b01, 16'h6000}) begin
         failures++;
         $display("FAIL reg_ca0 got=%b/%h exp=01/6000", req_ready, datain);
      end
      req_valid = 2'b00;
      step(1);
      checks++;
      if (datain !== 16'h0200) begin
         failures++;
         $display("FAIL reg_ca1 got=%h exp=0200", datain);
      end
      step(1);
      checks++;
      if (datain !== 16'h0000) begin
         failures++;
         $display("FAIL reg_ca2 got=%h exp=0000", datain);
      end
      step(1);
      checks++;
      if ({wr_ready, rwds_oe, datain} !== {3'b011, 16'hBEEF}) begin
         failures++;
         $display("FAIL reg_data got=%b/%h exp=011/beef", {wr_ready, rwds_oe}, datain);
      end
      step(1);
      checks++;
      if ({done, wr_ready, csn} !== 5'b01001) begin
         failures++;
         $display("FAIL reg_done got=%b exp=01001", {done, wr_ready, csn});
      end
      step(5);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int exp_g[4];
      int got;
`ifdef HRC_RR_ARB_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      req_write = 2'b11;
      req_reg   = 2'b11;
      req_addr  = '0;
      wr_data   = 32'h5555_AAAA;
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
         got = -1;
         for (int c = 0; c < 30 && got < 0; c++) begin
            step(1);
            if (req_ready == 2'b01)      got = 0;
            else if (req_ready == 2'b10) got = 1;
            else if (req_ready == 2'b11) got = 3;
         end
         if (g == 3) req_valid = 2'b00;
         checks++;
         if (got != exp_g[g]) begin
            failures++;
            $display("FAIL arb_grant%0d got=%0d exp=%0d", g, got, exp_g[g]);
         end
      end
      step(12);
      idle_inputs();
   endtask

   task automatic test_timeout();
      int k;
      req_valid = 2'b01;
      req_len   = '0;
      rwds_in   = 1'b0;
      step(1);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL tmo_grant got=%b exp=01", req_ready);
      end
      req_valid = 2'b00;
      k = 0;
      while (k < 200 && done == 2'b00) begin
         step(1);
         k++;
      end
      checks++;
      if (k != 73) begin
         failures++;
         $display("FAIL tmo_cycles got=%0d exp=73", k);
      end
      checks++;
      if ({done, err, csn, rd_valid} !== 6'b011100) begin
         failures++;
         $display("FAIL tmo_err got=%b exp=011100", {done, err, csn, rd_valid});
      end
      step(1);
      checks++;
      if ({done, err} !== 3'b000) begin
         failures++;
         $display("FAIL tmo_pulse got=%b exp=000", {done, err});
      end
      step(5);
   endtask

   task automatic test_reset_mid();
      int c;
      req_valid = 2'b10;
      req_write = 2'b10;
      req_reg   = 2'b00;
      req_addr  = '0;
      req_len   = {6'd3, 6'd0};
      wr_data   = {16'h3333, 16'h0000};
      step(1);
      req_valid = 2'b00;
      c = 0;
      while (c < 30 && wr_ready != 2'b10) begin
         step(1);
         c++;
      end
      checks++;
      if (wr_ready !== 2'b10) begin
         failures++;
         $display("FAIL rstmid_wdata got=%b exp=10", wr_ready);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({csn, oe_clk, oe_data, rwds_oe, wr_ready} !== 6'b100000) begin
         failures++;
         $display("FAIL rstmid_async got=%b exp=100000", {csn, oe_clk, oe_data, rwds_oe, wr_ready});
      end
      for (int i = 0; i < 2; i++) begin
         step(1);
         checks++;
         if (done !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_nodone got=%b exp=00", done);
         end
      end
      rst       = 1'b1;
      idle_inputs();
      req_valid = 2'b01;
      req_write = 2'b01;
      req_reg   = 2'b01;
      req_addr  = 64'h0000_0000_0000_1000;
      step(1);
      checks++;
      if ({req_ready, csn, datain} !== {3'b010, 16'h6000}) begin
         failures++;
         $display("FAIL rstmid_regrant got=%b/%h exp=010/6000", {req_ready, csn}, datain);
      end
      req_valid = 2'b00;
      c = 0;
      while (c < 20 && done == 2'b00) begin
         step(1);
         c++;
      end
      checks++;
      if ({done, c} !== {2'b01, 32'd4}) begin
         failures++;
         $display("FAIL rstmid_done got=%b@%0d exp=01@4", done, c);
      end
      step(5);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_reg_write();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
